// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose:
//   Bundles the signals between the pipeline front end and the hazard
//   controller. The pipeline datapath side uses the master modport. The hazard
//   controller uses the slave modport.
//
// Signal summary (direction seen from the slave / hazard controller):
//   rs, rt        in   5   ID-stage source register numbers
//   use_rs/use_rt in   1   ID instruction actually reads rs / rt
//   ewreg         in   1   EX instruction writes the register file
//   em2reg        in   1   EX instruction is a load
//   ern           in   5   EX destination register number
//   id_md         in   1   ID instruction is mult/div
//   id_hilo       in   1   ID instruction is mfhi/mflo
//   br_taken      in   1   ID branch/jump resolved taken
//   mem_hold      in   1   data memory not ready, freeze front end
//   wpcir         out  1   write enable for PC and IF/ID
//   bubble        out  1   force ID/EX control to NOP
//   flush_if      out  1   load NOP into IF/ID on next edge
//   md_start      out  1   start pulse to the mul/div unit
//   md_busy       out  1   mul/div unit occupied
//   md_done       out  1   mul/div result valid pulse
//   stall_cnt     out  32  stall-cycle counter (zero unless perf counting built in)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        use_rs;
   logic        use_rt;
   logic        ewreg;
   logic        em2reg;
   logic [4:0]  ern;
   logic        id_md;
   logic        id_hilo;
   logic        br_taken;
   logic        mem_hold;

   logic        wpcir;
   logic        bubble;
   logic        flush_if;
   logic        md_start;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt;

   modport master (
      output rs, rt, use_rs, use_rt, ewreg, em2reg, ern,
             id_md, id_hilo, br_taken, mem_hold,
      input  wpcir, bubble, flush_if, md_start, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  rs, rt, use_rs, use_rt, ewreg, em2reg, ern,
             id_md, id_hilo, br_taken, mem_hold,
      output wpcir, bubble, flush_if, md_start, md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Hazard and sequencing control for the IF/ID register and PC of the
//   5-stage pipeline. The block does the following:
//   - Detects load-use hazards.
//   - Holds the front end while the single multi-cycle mul/div unit is in use
//     by an instruction that needs it.
//   - Flushes IF/ID on taken branches.
//   - Freezes everything while data memory is not ready.
//   The mul/div unit is tracked by a small IDLE/RUN/DONE countdown FSM.
//
// Parameters:
//   MD_LAT  mul/div latency in cycles from md_start to md_done (>= 2)
//   CNT_W   countdown counter width, must hold MD_LAT-2
//
// Ports:
//   clk     in   system clock, all state on the rising edge
//   clrn    in   synchronous reset, active-high (1 = reset)
//   hz      slave side of pipe_hazard_ctrl_if (hazard inputs, control outputs)
//
// Build option:
//   HAZARD_STALL_PERF_EN  when defined, stall_cnt counts front-end stall cycles.
//                         The counter saturates at all-ones. When undefined,
//                         stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 6
) (
   input  logic               clk,
   input  logic               clrn,
   pipe_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // RUN lasts MD_LAT-1 cycles and DONE lasts one. The result is therefore
   // valid exactly MD_LAT cycles after the start pulse.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic rs_hit;
   logic rt_hit;
   logic lu;
   logic md_hz;
   logic unit_busy;

   logic wpcir_c;
   logic bubble_c;
   logic flush_c;
   logic start_c;

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   assign unit_busy = (state_q != IDLE);

   assign rs_hit = hz.use_rs && (hz.rs == hz.ern);
   assign rt_hit = hz.use_rt && (hz.rt == hz.ern);

   // Register 0 is hardwired to zero, so a load "into" it never creates a
   // real dependency.
   assign lu = hz.ewreg && hz.em2reg && (hz.ern != 5'd0) && (rs_hit || rt_hit);

   // A mult/div cannot start, and mfhi/mflo cannot read HI/LO, until the unit
   // has returned to IDLE. DONE still counts as busy, so the waiting
   // instruction proceeds on the first IDLE cycle.
   assign md_hz = (hz.id_md || hz.id_hilo) && unit_busy;

   // ---------------------------------------------------------------------
   // Front-end control, in priority order
   // ---------------------------------------------------------------------
   always_comb begin
      wpcir_c  = 1'b1;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
      start_c  = 1'b0;
      if (clrn) begin
         // While in reset the outputs keep their neutral values so the
         // surrounding pipeline sees a free-running front end.
      end else if (hz.mem_hold) begin
         // Full freeze. ID/EX must also hold, so no bubble is inserted.
         wpcir_c = 1'b0;
      end else if (lu || md_hz) begin
         wpcir_c  = 1'b0;
         bubble_c = 1'b1;
      end else begin
         // A branch that is stalled never flushes here. It is seen again on
         // the cycle its stall clears.
         flush_c = hz.br_taken;
         start_c = hz.id_md;
      end
   end

   assign hz.wpcir    = wpcir_c;
   assign hz.bubble   = bubble_c;
   assign hz.flush_if = flush_c;
   assign hz.md_start = start_c;

   // ---------------------------------------------------------------------
   // Mul/div occupancy FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               state_d = RUN;
               cnt_d   = CNT_LOAD;
            end
         end
         RUN: begin
            // mem_hold does not pause the countdown. The unit runs
            // independently of the front-end freeze.
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         // An operation still in flight is dropped with no md_done pulse.
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.md_busy = unit_busy;
   assign hz.md_done = (state_q == DONE);

   // ---------------------------------------------------------------------
   // Optional stall-cycle counter
   // ---------------------------------------------------------------------
`ifdef HAZARD_STALL_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (clrn) begin
         stall_cnt_q <= '0;
      end else if (!wpcir_c) begin
         stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
`else
   assign hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic clrn;

   pipe_hazard_ctrl_if bus();

   pipe_hazard_ctrl #(.MD_LAT(LAT), .CNT_W(6)) dut (
      .clk  (clk),
      .clrn (clrn),
      .hz   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model. The mul/div unit is tracked by the cycle on which it
   // was started. The unit is busy on cycles start+1 .. start+LAT, and done
   // is reported on cycle start+LAT. Cycle numbers advance on each negedge.
   // ---------------------------------------------------------------------
   int          cyc       = 0;
   int          start_cyc = -1;
   bit          known     = 1'b0;
   logic [31:0] m_stall   = 32'd0;

   always @(negedge clk) begin
      logic e_lu, e_busy, e_done, e_hz, e_w, e_b, e_f, e_s;
      logic [31:0] e_stall;
      e_lu = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
             ((bus.use_rs && bus.rs == bus.ern) || (bus.use_rt && bus.rt == bus.ern));
      e_busy = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + LAT);
      e_done = (start_cyc >= 0) && (cyc == start_cyc + LAT);
      e_hz   = (bus.id_md || bus.id_hilo) && e_busy;
      e_w = 1'b1; e_b = 1'b0; e_f = 1'b0; e_s = 1'b0;
      if (clrn) begin
         e_w = 1'b1;
      end else if (bus.mem_hold) begin
         e_w = 1'b0;
      end else if (e_lu || e_hz) begin
         e_w = 1'b0; e_b = 1'b1;
      end else begin
         e_f = bus.br_taken; e_s = bus.id_md;
      end
`ifdef HAZARD_STALL_PERF_EN
      e_stall = m_stall;
`else
      e_stall = 32'd0;
`endif
      chk("m_wpcir",    {31'd0, bus.wpcir},    {31'd0, e_w});
      chk("m_bubble",   {31'd0, bus.bubble},   {31'd0, e_b});
      chk("m_flush_if", {31'd0, bus.flush_if}, {31'd0, e_f});
      chk("m_md_start", {31'd0, bus.md_start}, {31'd0, e_s});
      if (known) begin
         chk("m_md_busy",   {31'd0, bus.md_busy}, {31'd0, e_busy});
         chk("m_md_done",   {31'd0, bus.md_done}, {31'd0, e_done});
         chk("m_stall_cnt", bus.stall_cnt,        e_stall);
      end
      // Advance the model across the coming rising edge.
      if (clrn) begin
         start_cyc = -1;
         m_stall   = 32'd0;
         known     = 1'b1;
      end else begin
         if (e_s) start_cyc = cyc;
         if (!e_w && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      cyc++;
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.rs = 5'd0;       bus.rt = 5'd0;
      bus.use_rs = 1'b0;   bus.use_rt = 1'b0;
      bus.ewreg = 1'b0;    bus.em2reg = 1'b0;   bus.ern = 5'd0;
      bus.id_md = 1'b0;    bus.id_hilo = 1'b0;
      bus.br_taken = 1'b0; bus.mem_hold = 1'b0;
   endtask

   task automatic set_lu();
      bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd5;
      bus.rs = 5'd5;    bus.use_rs = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_perf;
      clrn = 1'b1;
      idle_in();
      step(); step();

      // Outputs are forced neutral while reset is held.
      bus.id_md = 1'b1; bus.br_taken = 1'b1; set_lu();
      #2;
      chk("rst_wpcir",    {31'd0, bus.wpcir},    32'd1);
      chk("rst_bubble",   {31'd0, bus.bubble},   32'd0);
      chk("rst_flush_if", {31'd0, bus.flush_if}, 32'd0);
      chk("rst_md_start", {31'd0, bus.md_start}, 32'd0);
      step(); #2;
      chk("rst_md_busy",   {31'd0, bus.md_busy}, 32'd0);
      chk("rst_md_done",   {31'd0, bus.md_done}, 32'd0);
      chk("rst_stall_cnt", bus.stall_cnt,        32'd0);
      clrn = 1'b0; idle_in();
      step();

      // Load-use on rs=5, then cleared, then the same pattern on register 0.
      set_lu(); #2;
      chk("lu_wpcir",  {31'd0, bus.wpcir},  32'd0);
      chk("lu_bubble", {31'd0, bus.bubble}, 32'd1);
      step(); idle_in(); #2;
      chk("lu_next_wpcir",  {31'd0, bus.wpcir},  32'd1);
      chk("lu_next_bubble", {31'd0, bus.bubble}, 32'd0);
      set_lu(); bus.ern = 5'd0; bus.rs = 5'd0; #2;
      chk("r0_wpcir",  {31'd0, bus.wpcir},  32'd1);
      chk("r0_bubble", {31'd0, bus.bubble}, 32'd0);
      step(); idle_in();

      // Branch alone, then branch under a load-use stall.
      bus.br_taken = 1'b1; #2;
      chk("br_flush_if", {31'd0, bus.flush_if}, 32'd1);
      chk("br_wpcir",    {31'd0, bus.wpcir},    32'd1);
      set_lu(); #2;
      chk("brlu_flush_if", {31'd0, bus.flush_if}, 32'd0);
      chk("brlu_wpcir",    {31'd0, bus.wpcir},    32'd0);
      step(); idle_in();

      // Mul/div start at T, mfhi waiting from T+1.
      bus.id_md = 1'b1; #2;
      chk("md_start_T", {31'd0, bus.md_start}, 32'd1);
      chk("md_busy_T",  {31'd0, bus.md_busy},  32'd0);
      step(); idle_in(); bus.id_hilo = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         #2;
         chk("md_busy_run",   {31'd0, bus.md_busy}, 32'd1);
         chk("md_done_run",   {31'd0, bus.md_done}, (k == LAT) ? 32'd1 : 32'd0);
         chk("hilo_wpcir",    {31'd0, bus.wpcir},   32'd0);
         chk("hilo_bubble",   {31'd0, bus.bubble},  32'd1);
         step();
      end
      #2;
      chk("hilo_go_wpcir", {31'd0, bus.wpcir},   32'd1);
      chk("md_busy_after", {31'd0, bus.md_busy}, 32'd0);
      chk("md_done_after", {31'd0, bus.md_done}, 32'd0);
      step(); idle_in();

      // Memory hold with load-use during RUN; the countdown keeps going.
      bus.id_md = 1'b1; #2;
      chk("mh_start", {31'd0, bus.md_start}, 32'd1);
      step(); idle_in(); bus.mem_hold = 1'b1; set_lu();
      for (int k = 1; k <= LAT; k++) begin
         #2;
         chk("mh_wpcir",  {31'd0, bus.wpcir},   32'd0);
         chk("mh_bubble", {31'd0, bus.bubble},  32'd0);
         chk("mh_done",   {31'd0, bus.md_done}, (k == LAT) ? 32'd1 : 32'd0);
         step();
      end
      idle_in();
      step();

      // Reset in the middle of an operation.
      bus.id_md = 1'b1;
      step(); idle_in();
      step(); clrn = 1'b1; #2;
      chk("rmo_busy_in_rst", {31'd0, bus.md_busy}, 32'd1);
      chk("rmo_wpcir",       {31'd0, bus.wpcir},   32'd1);
      step(); clrn = 1'b0; #2;
      chk("rmo_busy", {31'd0, bus.md_busy}, 32'd0);
      chk("rmo_done", {31'd0, bus.md_done}, 32'd0);
      chk("rmo_stall_cnt", bus.stall_cnt, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(); #2;
         chk("rmo_no_done", {31'd0, bus.md_done}, 32'd0);
      end

      // Seven load-use stall cycles since the last reset.
      set_lu();
      repeat (6) step();
      step(); idle_in(); #2;
`ifdef HAZARD_STALL_PERF_EN
      exp_perf = 32'd7;
`else
      exp_perf = 32'd0;
`endif
      chk("perf_seven", bus.stall_cnt, exp_perf);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         step();
         clrn         = ($urandom_range(99) == 0);
         bus.rs       = 5'($urandom_range(7));
         bus.rt       = 5'($urandom_range(7));
         bus.ern      = 5'($urandom_range(7));
         bus.use_rs   = 1'($urandom_range(1));
         bus.use_rt   = 1'($urandom_range(1));
         bus.ewreg    = 1'($urandom_range(1));
         bus.em2reg   = ($urandom_range(2) == 0);
         bus.id_md    = ($urandom_range(4) == 0);
         bus.id_hilo  = ($urandom_range(6) == 0);
         bus.br_taken = ($urandom_range(3) == 0);
         bus.mem_hold = ($urandom_range(9) == 0);
      end
      step(); idle_in(); clrn = 1'b0;
      step(); step();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
